// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } sar_state_t;

    localparam int MAX_W = 64;

    // Flip the sign bit of a width-bit value: two's complement <-> offset binary.
    function automatic logic [MAX_W-1:0] to_offset(input logic [MAX_W-1:0] x, input int width);
        return x ^ (MAX_W'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Start/probe/answer/result bundle between the search controller and its comparator side.
interface sar_search_ctrl_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] probe;
    logic         probe_valid;
    logic         lt_in;
    logic         lt_valid;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        input  start, lt_in, lt_valid,
        output probe, probe_valid, busy, done, result
    );

    modport slave (
        output start, lt_in, lt_valid,
        input  probe, probe_valid, busy, done, result
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Signed successive-approximation search: one probe per accepted less-than answer,
// MSB first, producing the unknown's exact N-bit two's-complement value.
module sar_search_ctrl
    import sar_pkg::*;
#(
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    sar_search_ctrl_if.master  bus
);

    sar_state_t   state_reg;
    logic [N-1:0] trial_reg;
    logic [IW-1:0] index_reg;
    logic [N-1:0] probe_reg;
    logic         probe_valid_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [N-1:0] result_reg;

    logic [N-1:0] trial_upd;
    logic [N-1:0] trial_next;

    localparam logic [N-1:0] MID_CODE = N'(MAX_W'(1) << (N - 1));

    // trial_upd resolves the current bit from the answer; trial_next also arms the next bit.
    always_comb begin
        trial_upd = trial_reg;
        if (bus.lt_in) begin
            trial_upd[index_reg] = 1'b0;
        end
        trial_next = trial_upd;
        if (index_reg != '0) begin
            trial_next[index_reg - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            trial_reg       <= '0;
            index_reg       <= IW'(N - 1);
            probe_reg       <= '0;
            probe_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            result_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        trial_reg       <= MID_CODE;
                        index_reg       <= IW'(N - 1);
                        probe_reg       <= N'(to_offset(MAX_W'(MID_CODE), N));
                        probe_valid_reg <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (bus.lt_valid) begin
                        if (index_reg != '0) begin
                            trial_reg <= trial_next;
                            index_reg <= index_reg - 1'b1;
                            probe_reg <= N'(to_offset(MAX_W'(trial_next), N));
                        end else begin
                            trial_reg       <= trial_upd;
                            probe_reg       <= N'(to_offset(MAX_W'(trial_upd), N));
                            result_reg      <= N'(to_offset(MAX_W'(trial_upd), N));
                            probe_valid_reg <= 1'b0;
                            done_reg        <= 1'b1;
                            state_reg       <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately not sampled here; a new search needs an IDLE cycle.
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg       <= S_IDLE;
                    probe_valid_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.probe       = probe_reg;
    assign bus.probe_valid = probe_valid_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.result      = result_reg;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl (N=8): behavioural less-than responder with programmable delay,
// table vectors, hand sequences for restart/reset corners, and a random plus exhaustive sweep.
module tb_sar_search_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sar_search_ctrl_if #(.N(N)) bus ();

    sar_search_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] unknown    = 8'h00;
    int         resp_delay = 0;
    bit         idle_noise = 1'b0;
    int         hold_cnt   = 0;
    logic [7:0] probe_log [8];

    typedef struct {
        logic [7:0] unknown;
        int         delay;
        bit         repulse;
        logic [7:0] exp_result;
        int         exp_cycles;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Comparator responder: answers unknown < probe after resp_delay waiting cycles per probe.
    initial begin
        bus.lt_valid = 1'b0;
        bus.lt_in    = 1'b0;
    end

    always @(negedge clk) begin
        if (rst || !bus.probe_valid) begin
            bus.lt_valid = idle_noise;
            bus.lt_in    = idle_noise;
            hold_cnt     = 0;
        end else begin
            if (bus.lt_valid) hold_cnt = 0;
            bus.lt_valid = (hold_cnt >= resp_delay);
            bus.lt_in    = ($signed(unknown) < $signed(bus.probe));
            if (!bus.lt_valid) hold_cnt++;
        end
    end

    // One full search; the probe sequence is checked against an interval-halving model.
    task automatic run_search(input logic [7:0] unk, input int d, input bit repulse,
                              output logic [7:0] res, output int cycles);
        int lo, step, pexp, n_acc, dones, extra;
        bit seq_ok, busy_ok;
        unknown    = unk;
        resp_delay = d;
        lo = -128; step = 128; n_acc = 0; dones = 0; extra = 0;
        seq_ok = 1'b1; busy_ok = 1'b1; cycles = 0; res = 8'h00;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 400 && dones == 0; c++) begin
            @(negedge clk);
            #1;
            bus.start = (repulse && (c == 3 || c == 4));
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.probe_valid && bus.lt_valid) begin
                pexp = lo + step;
                if ($signed(bus.probe) != pexp) seq_ok = 1'b0;
                if (n_acc < 8) probe_log[n_acc] = bus.probe;
                if (!($signed(unk) < pexp)) lo = pexp;
                step = step / 2;
                n_acc++;
            end
            if (bus.done) begin
                dones++;
                cycles = c;
                res    = bus.result;
            end
        end
        bus.start = 1'b0;
        check("search_finished", 64'(dones), 64'd1);
        check("probe_sequence", 64'(seq_ok), 64'd1);
        check("answer_count", 64'(n_acc), 64'd8);
        check("busy_during_search", 64'(busy_ok), 64'd1);
        @(negedge clk);
        #1;
        check("idle_after_done", 64'(bus.busy), 64'd0);
        if (bus.done) extra++;
        @(negedge clk);
        #1;
        if (bus.done) extra++;
        check("single_done", 64'(extra), 64'd0);
    endtask

    initial begin
        automatic vec_t vec [7];
        automatic logic [7:0] exp_probes [8] = '{8'h00, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        logic [7:0] res, unk8;
        int cyc, d, n_done, n_acc;
        int done_at[$];
        bit ok;

        vec[0] = '{8'h00, 0, 1'b0, 8'h00, 9};
        vec[1] = '{8'h80, 0, 1'b0, 8'h80, 9};
        vec[2] = '{8'h7F, 0, 1'b0, 8'h7F, 9};
        vec[3] = '{8'hFF, 0, 1'b0, 8'hFF, 9};
        vec[4] = '{8'd37, 3, 1'b0, 8'h25, 33};
        vec[5] = '{8'hCE, 0, 1'b1, 8'hCE, 9};
        vec[6] = '{8'd5,  1, 1'b0, 8'h05, 17};

        bus.start = 1'b0;
        #3;
        check("rst_probe", 64'(bus.probe), 64'd0);
        check("rst_probe_valid", 64'(bus.probe_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_search(vec[i].unknown, vec[i].delay, vec[i].repulse, res, cyc);
            $display("vec %0d: unknown=0x%02h delay=%0d result=0x%02h cycles=%0d", i, vec[i].unknown, vec[i].delay, res, cyc);
            check("vec_result", 64'(res), 64'(vec[i].exp_result));
            check("vec_latency", 64'(cyc), 64'(vec[i].exp_cycles));
            if (i == 0) begin
                for (int k = 0; k < 8; k++) check("zero_probe", 64'(probe_log[k]), 64'(exp_probes[k]));
            end
        end

        // lt_valid pulses while idle must not start anything.
        idle_noise = 1'b1;
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus.busy || bus.done || bus.probe_valid) ok = 1'b0;
        end
        idle_noise = 1'b0;
        $display("idle lt_valid noise: stayed idle=%0d", ok);
        check("idle_ignores_lt_valid", 64'(ok), 64'd1);

        // start held high: back-to-back searches separated by one IDLE cycle.
        unknown = 8'd77;
        resp_delay = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            #1;
            if (bus.done) begin
                done_at.push_back(c);
                check("held_start_result", 64'(bus.result), 64'd77);
            end
        end
        bus.start = 1'b0;
        $display("held start: %0d done pulses", done_at.size());
        check("held_start_dones", 64'(done_at.size()), 64'd3);
        if (done_at.size() >= 2) check("held_start_period", 64'(done_at[1] - done_at[0]), 64'(N + 2));
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (!bus.busy) ok = 1'b1;
        end
        check("held_start_drain", 64'(ok), 64'd1);

        // Asynchronous reset after four answers: immediate clear, no done.
        unknown = 8'd100;
        @(negedge clk);
        bus.start = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 4; c++) begin
            @(negedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.probe_valid && bus.lt_valid) n_acc++;
        end
        check("reset_reached_4_answers", 64'(n_acc), 64'd4);
        #2 rst = 1'b1;
        #1;
        $display("mid-search reset: probe=0x%02h pv=%0d busy=%0d result=0x%02h", bus.probe, bus.probe_valid, bus.busy, bus.result);
        check("abort_probe", 64'(bus.probe), 64'd0);
        check("abort_probe_valid", 64'(bus.probe_valid), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        run_search(8'd5, 0, 1'b0, res, cyc);
        $display("after reset: unknown=0x05 result=0x%02h cycles=%0d", res, cyc);
        check("post_reset_result", 64'(res), 64'h05);

        // Random unknowns with random responder delay.
        for (int i = 0; i < 1000; i++) begin
            unk8 = 8'($urandom);
            d = int'($urandom_range(0, 2));
            run_search(unk8, d, 1'b0, res, cyc);
            $display("rand %0d: unknown=0x%02h delay=%0d result=0x%02h cycles=%0d", i, unk8, d, res, cyc);
            check("rand_result", 64'(res), 64'(unk8));
            check("rand_latency", 64'(cyc), 64'(N * (d + 1) + 1));
        end

        // Exhaustive signed range.
        for (int v = -128; v < 128; v++) begin
            unk8 = 8'(v);
            run_search(unk8, 0, 1'b0, res, cyc);
            $display("sweep %0d: result=0x%02h cycles=%0d", v, res, cyc);
            check("sweep_result", 64'(res), 64'(unk8));
            check("sweep_latency", 64'(cyc), 64'(N + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller: the initiator side of a signed less-than compare.
- On start, it drives a sequence of N signed probe values to an external comparator, which answers whether the unknown is less than the probe. After N answers it returns the unknown's exact N-bit two's-complement value.
- The parent instantiates comparator_lt as the responder, with a = unknown and b = probe.
- Intended for SAR-style ADC and threshold-search datapaths.

Parameters:
- N, 32, data width of probe/result in bits (two's complement), N >= 2.
- IW, $clog2(N), width of the internal bit-index counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a search; sampled only in IDLE.
- probe  output  N  signed trial value presented to the comparator.
- probe_valid  output  1  probe is stable and awaiting an answer.
- lt_in  input  1  comparator answer: 1 = unknown < probe.
- lt_valid  input  1  lt_in is valid this cycle.
- busy  output  1  search in progress (state != IDLE).
- done  output  1  one-cycle pulse: result valid.
- result  output  N  signed search result, held until the next accepted start.

Behaviour:
- Reset (async, active-high): state=IDLE, probe=0, probe_valid=0, busy=0, done=0, result=0, trial=0, index=N-1.
- Internal trial register holds offset-binary code u; the signed value is u ^ (1<<(N-1)). probe is always trial ^ (1<<(N-1)) (registered).
- State IDLE:
  - start=1 -> trial = 1<<(N-1), index = N-1, go to PROBE. The first probe is therefore signed 0.
  - Otherwise hold. result holds its last value.
- State PROBE:
  - probe_valid=1. probe is held stable until an answer is accepted.
  - Answer accepted on any rising edge where lt_valid=1.
  - On acceptance: if lt_in=1, clear trial[index]; else keep it.
  - If index>0: set trial[index-1]=1, decrement index, stay in PROBE.
  - If index=0: go to DONE and latch result = finalized trial ^ (1<<(N-1)).
- State DONE: done=1, probe_valid=0, busy=1 for exactly one cycle -> IDLE.
- lt_valid outside PROBE is ignored. lt_valid may be asserted in the same cycle probe_valid first rises; this supports a purely combinational responder.
- Latency: with lt_valid tied high, start-accept to done pulse is N+1 cycles (N PROBE cycles + DONE). With a responder delay of D cycles per answer, it is N*(D+1)+1.
- start while busy (PROBE or DONE) is ignored, with no restart.
- start in the same cycle that DONE is left (DONE->IDLE) is ignored. Start is sampled only while in IDLE.
- Reset mid-search: immediate abort to reset values. result reverts to 0 and no done pulse is issued.
- Full-range correctness is required: the result equals the unknown for every value from -2^(N-1) to 2^(N-1)-1.

Decomposition:
- Package sar_pkg:
  - state enum sar_state_t {S_IDLE, S_PROBE, S_DONE} (2 bits).
  - Function to_offset(x) = x ^ MSB mask, parameterized via width argument.
- No sub-module inside the block.
- Bench pairs it with comparator_lt (N-wide) as the responder, optionally through a delay-line wrapper to exercise lt_valid latency.

Test Plan (N=8, comparator_lt responder, lt_valid=probe_valid unless noted):
- Unknown=0, start pulse -> probes 0x00, 0x40, 0x20, 0x10, 0x08, 0x04, 0x02, 0x01. done on cycle 9 after start, result=0x00.
- Unknown=-128 (0x80) -> first probe 0x00 answered lt=1. done with result=0x80. Unknown=127 -> result=0x7F. Unknown=-1 -> result=0xFF. These cover the sign-bit and overflow boundaries.
- Unknown=37, lt_valid delayed 3 cycles per probe -> each probe held 4 cycles. done at cycle 8*4+1=33, result=0x25.
- start re-pulsed during PROBE (unknown=-50) -> sequence unaffected, a single done pulse, result=0xCE. start held high continuously -> searches run back-to-back, separated by 1 IDLE cycle.
- rst asserted asynchronously mid-cycle after 4 probes -> outputs 0 immediately and no done. A new start with unknown=5 yields result=0x05.
- Random sweep: 1000 random unknowns plus an exhaustive -128..127 sweep -> result==unknown, exactly one done per accepted start, busy low only in IDLE.
